ball_dir_ctrl: RTL

BALL_DIR_CTRL -- requirements
Module: ball_dir_ctrl

---
 rtl/ball_dir_ctrl.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/ball_dir_ctrl.sv
// Ball direction controller for the brick-breaker playfield.
// On each movement tick it resolves wall and paddle bounces, asks the brick
// map whether the next position overlaps a live brick, and then issues a
// single move enable carrying the final direction to the position counter.

module ball_dir_ctrl #(
    parameter int SCREEN_W  = 320,
    parameter int SCREEN_H  = 240,
    parameter int BALL_SIZE = 2,
    parameter int PADDLE_Y  = 220,
    parameter int PADDLE_W  = 32
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       tick,
    input  logic       launch,
    input  logic [9:0] ball_x,
    input  logic [9:0] ball_y,
    input  logic [9:0] paddle_x,
    input  logic       brick_ack,
    input  logic       brick_hit,
    output logic       x_du,
    output logic       y_du,
    output logic       move_en,
    output logic       brick_req,
    output logic [9:0] query_x,
    output logic [9:0] query_y,
    output logic       ball_lost,
    output logic       playing
);

    typedef enum logic [2:0] {
        IDLE,
        PLAY,
        CHECK,
        BRICK,
        MOVE,
        LOST
    } state_t;

    // Geometry limits widened to 11 bits so sums of coordinates never wrap.
    localparam logic [10:0] RIGHT_LIMIT = 11'(SCREEN_W - BALL_SIZE);
    localparam logic [10:0] FLOOR_LIMIT = 11'(SCREEN_H - BALL_SIZE);
    localparam logic [10:0] PADDLE_TOP  = 11'(PADDLE_Y);
    localparam logic [10:0] BALL_EXT    = 11'(BALL_SIZE);
    localparam logic [10:0] PAD_WIDTH   = 11'(PADDLE_W);

    state_t      state;

    logic [10:0] bx;
    logic [10:0] by;
    logic [10:0] px;

    logic        hit_right;
    logic        hit_left;
    logic        hit_top;
    logic        hit_paddle;
    logic        hit_floor;
    logic        next_x;
    logic        next_y;
    logic [9:0]  next_qx;
    logic [9:0]  next_qy;

    assign bx = {1'b0, ball_x};
    assign by = {1'b0, ball_y};
    assign px = {1'b0, paddle_x};

    // Bounce decisions for the current position; X and Y resolve independently so a corner flips both.
    always_comb begin
        hit_right  = x_du && (bx >= RIGHT_LIMIT);
        hit_left   = !x_du && (bx == 11'd0);
        hit_top    = !y_du && (by == 11'd0);
        hit_paddle = y_du && ((by + BALL_EXT) == PADDLE_TOP)
                     && ((bx + BALL_EXT) > px) && (bx < (px + PAD_WIDTH));
        hit_floor  = y_du && (by >= FLOOR_LIMIT) && !hit_paddle;

        next_x = x_du;
        if (hit_right) begin
            next_x = 1'b0;
        end else if (hit_left) begin
            next_x = 1'b1;
        end

        next_y = y_du;
        if (hit_top) begin
            next_y = 1'b1;
        end else if (hit_paddle) begin
            next_y = 1'b0;
        end

        next_qx = next_x ? (ball_x + 10'd1) : (ball_x - 10'd1);
        next_qy = next_y ? (ball_y + 10'd1) : (ball_y - 10'd1);
    end

    // Main control FSM; every output is registered and reset wins over any open handshake.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state     <= IDLE;
            x_du      <= 1'b1;
            y_du      <= 1'b0;
            move_en   <= 1'b0;
            brick_req <= 1'b0;
            query_x   <= 10'd0;
            query_y   <= 10'd0;
            ball_lost <= 1'b0;
            playing   <= 1'b0;
        end else begin
            move_en   <= 1'b0;
            ball_lost <= 1'b0;
            case (state)
                IDLE: begin
                    if (launch) begin
                        state   <= PLAY;
                        playing <= 1'b1;
                    end
                end
                PLAY: begin
                    if (tick) begin
                        state <= CHECK;
                    end
                end
                CHECK: begin
                    x_du <= next_x;
                    y_du <= next_y;
                    if (hit_floor) begin
                        state     <= LOST;
                        ball_lost <= 1'b1;
                    end else begin
                        state     <= BRICK;
                        brick_req <= 1'b1;
                        query_x   <= next_qx;
                        query_y   <= next_qy;
                    end
                end
                BRICK: begin
                    if (brick_ack) begin
                        brick_req <= 1'b0;
                        move_en   <= 1'b1;
                        state     <= MOVE;
                        if (brick_hit) begin
                            y_du <= ~y_du;
                        end
                    end
                end
                MOVE: begin
                    state <= PLAY;
                end
                LOST: begin
                    x_du    <= 1'b1;
                    y_du    <= 1'b0;
                    playing <= 1'b0;
                    state   <= IDLE;
                end
                default: begin
                    state   <= IDLE;
                    playing <= 1'b0;
                end
            endcase
        end
    end

endmodule
